// File: rtl/lpc_host_tx.sv
// LPC host transmit engine: takes one memory/IO cycle request, serialises it
// onto the LAD bus, waits on peripheral SYNC and returns a completion.
// Optional feature macro: LPC_HOST_ABORT_EN (drive an LFRAME# abort on timeout).
`timescale 1ns/1ps
module lpc_host_tx #(
  parameter int SYNC_TIMEOUT = 8
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cyctype_dir,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_data_size,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  input  logic [3:0]  lpc_ad_in,
  output logic        lpc_frame,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_status
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] START  = 4'd1;
  localparam logic [3:0] CTDIR  = 4'd2;
  localparam logic [3:0] SIZE   = 4'd3;
  localparam logic [3:0] ADDR   = 4'd4;
  localparam logic [3:0] WDATA  = 4'd5;
  localparam logic [3:0] TAR_H  = 4'd6;
  localparam logic [3:0] TAR_Z  = 4'd7;
  localparam logic [3:0] SYNC   = 4'd8;
  localparam logic [3:0] RDATA  = 4'd9;
  localparam logic [3:0] TAR_P1 = 4'd10;
  localparam logic [3:0] TAR_P2 = 4'd11;
  localparam logic [3:0] ABORT  = 4'd12;

  localparam int TW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(SYNC_TIMEOUT);

  logic [3:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [1:0]    stat_q, stat_d;
  logic          armed_q, armed_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic [1:0]    resp_status_q, resp_status_d;
  logic [3:0]    ct_q, ct_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    last_nib;
  logic          done;

  // Next-state, nibble sequencing, SYNC decoding and completion capture
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    stat_d        = stat_q;
    armed_d       = 1'b1;
    resp_valid_d  = 1'b0;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    ct_d          = ct_q;
    size_d        = size_q;
    addr_d        = addr_q;
    data_d        = data_q;
    rdata_d       = rdata_q;
    done          = 1'b0;
    tmo_inc       = tmo_q + 1'b1;
    // Size code 2 is promoted to 3 at latch time, so only 0/1/3 appear here
    last_nib      = (size_q == 2'd0) ? 3'd1 : (size_q == 2'd1) ? 3'd3 : 3'd7;
    case (state_q)
      IDLE: begin
        if (req_valid && armed_q) begin
          ct_d    = req_cyctype_dir;
          size_d  = (req_data_size == 2'd2) ? 2'd3 : req_data_size;
          addr_d  = req_addr;
          data_d  = req_data;
          rdata_d = 32'd0;
          stat_d  = 2'd0;
          tmo_d   = '0;
          cnt_d   = 3'd0;
          state_d = START;
        end
      end
      START: state_d = CTDIR;
      CTDIR: state_d = SIZE;
      SIZE: begin
        cnt_d   = 3'd0;
        state_d = ADDR;
      end
      ADDR: begin
        addr_d = {addr_q[27:0], 4'h0};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          cnt_d   = 3'd0;
          state_d = ct_q[1] ? WDATA : TAR_H;
        end
      end
      WDATA: begin
        data_d = {4'h0, data_q[31:4]};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == last_nib) begin
          cnt_d   = 3'd0;
          state_d = TAR_H;
        end
      end
      TAR_H: state_d = TAR_Z;
      TAR_Z: begin
        tmo_d   = '0;
        state_d = SYNC;
      end
      SYNC: begin
        cnt_d = 3'd0;
        if (lpc_ad_in == 4'b0000) begin
          state_d = ct_q[1] ? TAR_P1 : RDATA;
        end else if (lpc_ad_in == 4'b1010) begin
          stat_d  = 2'd1;
          state_d = ct_q[1] ? TAR_P1 : RDATA;
        end else if (lpc_ad_in == 4'b0110) begin
          tmo_d = '0;
        end else if (tmo_inc == TMO_MAX) begin
          tmo_d  = '0;
          stat_d = 2'd2;
`ifdef LPC_HOST_ABORT_EN
          state_d = ABORT;
`else
          state_d = IDLE;
          done    = 1'b1;
`endif
        end else begin
          tmo_d = tmo_inc;
        end
      end
      RDATA: begin
        rdata_d[{cnt_q, 2'b00} +: 4] = lpc_ad_in;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == last_nib) begin
          cnt_d   = 3'd0;
          state_d = TAR_P1;
        end
      end
      TAR_P1: state_d = TAR_P2;
      TAR_P2: begin
        state_d = IDLE;
        done    = 1'b1;
      end
`ifdef LPC_HOST_ABORT_EN
      ABORT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          cnt_d   = 3'd0;
          state_d = IDLE;
          done    = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (done) begin
      resp_valid_d  = 1'b1;
      resp_data_d   = rdata_q;
      resp_status_d = stat_d;
    end
  end

  // LAD / LFRAME# drive decoded from the current state
  always_comb begin
    lpc_frame  = 1'b1;
    lpc_ad_oe  = 1'b0;
    lpc_ad_out = 4'hF;
    case (state_q)
      START: begin
        lpc_frame  = 1'b0;
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = 4'h0;
      end
      CTDIR: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = ct_q;
      end
      SIZE: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = {2'b00, size_q};
      end
      ADDR: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = addr_q[31:28];
      end
      WDATA: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = data_q[3:0];
      end
      TAR_H: lpc_ad_oe = 1'b1;
`ifdef LPC_HOST_ABORT_EN
      ABORT: begin
        if (cnt_q < 3'd4) begin
          lpc_frame = 1'b0;
          lpc_ad_oe = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign req_ready   = armed_q && (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_status = resp_status_q;

  // Control and completion registers; reset abandons any cycle in flight
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      tmo_q         <= '0;
      stat_q        <= 2'd0;
      armed_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= 32'd0;
      resp_status_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      stat_q        <= stat_d;
      armed_q       <= armed_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
    end
  end

  // Request payload and read shift registers, only meaningful inside a cycle
  always_ff @(posedge lpc_clock) begin
    ct_q    <= ct_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    data_q  <= data_d;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_lpc_host_tx.sv
// Testbench for lpc_host_tx: transaction-level bus model plus LPC sniffer.
`timescale 1ns/1ps
module tb_lpc_host_tx;
  localparam int TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_ct;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic [3:0]  ad_out;
  logic        ad_oe;
  logic [3:0]  ad_in;
  logic        frame;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_status;

  lpc_host_tx #(.SYNC_TIMEOUT(TMO)) dut (
    .lpc_clock(clk), .lpc_reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cyctype_dir(req_ct), .req_addr(req_addr), .req_data(req_data),
    .req_data_size(req_size),
    .lpc_ad_out(ad_out), .lpc_ad_oe(ad_oe), .lpc_ad_in(ad_in),
    .lpc_frame(frame),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_status(resp_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        fr;
    logic        oe;
    logic [3:0]  ad;
    logic [3:0]  din;
    logic        rv;
    logic        rdy;
    logic [31:0] rd;
    logic [1:0]  rs;
  } ent_t;

  ent_t       plan[$];
  ent_t       expq[$];
  logic [3:0] per_q[$];
  int         checks;
  int         errors;
  int         ent_no;
  bit         idle_chk;

  function automatic ent_t mk(logic fr, logic oe, logic [3:0] ad, logic [3:0] din);
    ent_t e;
    e = '0;
    e.fr = fr; e.oe = oe; e.ad = ad; e.din = din;
    return e;
  endfunction

  // Whole-cycle expectation from the request and the peripheral's reply list
  task automatic build_plan(input logic [3:0] ct, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] data);
    int nb, cnt;
    logic [1:0] szn, st;
    logic [31:0] rd;
    logic [3:0] d;
    bit to;
    ent_t e;
    szn = (sz == 2'd2) ? 2'd3 : sz;
    nb  = (szn == 2'd0) ? 1 : (szn == 2'd1) ? 2 : 4;
    plan.delete();
    plan.push_back(mk(1'b0, 1'b1, 4'h0, 4'h0));
    plan.push_back(mk(1'b1, 1'b1, ct, 4'h0));
    plan.push_back(mk(1'b1, 1'b1, {2'b00, szn}, 4'h0));
    for (int i = 0; i < 8; i++) plan.push_back(mk(1'b1, 1'b1, 4'(addr >> (28 - 4 * i)), 4'h0));
    if (ct[1]) for (int i = 0; i < 2 * nb; i++) plan.push_back(mk(1'b1, 1'b1, 4'(data >> (4 * i)), 4'h0));
    plan.push_back(mk(1'b1, 1'b1, 4'hF, 4'h0));
    plan.push_back(mk(1'b1, 1'b0, 4'hF, 4'h0));
    cnt = 0; st = 2'd0; to = 1'b0;
    for (int g = 0; g < 1000; g++) begin
      d = 4'hF;
      if (per_q.size() > 0) d = per_q.pop_front();
      plan.push_back(mk(1'b1, 1'b0, 4'hF, d));
      if (d == 4'h0) break;
      if (d == 4'hA) begin st = 2'd1; break; end
      if (d == 4'h6) cnt = 0;
      else begin
        cnt++;
        if (cnt == TMO) begin st = 2'd2; to = 1'b1; break; end
      end
    end
    rd = 32'd0;
    if (!to) begin
      if (!ct[1]) for (int i = 0; i < 2 * nb; i++) begin
        d = 4'h0;
        if (per_q.size() > 0) d = per_q.pop_front();
        plan.push_back(mk(1'b1, 1'b0, 4'hF, d));
        rd = rd | (32'(d) << (4 * i));
      end
      plan.push_back(mk(1'b1, 1'b0, 4'hF, 4'h0));
      plan.push_back(mk(1'b1, 1'b0, 4'hF, 4'h0));
    end else begin
`ifdef LPC_HOST_ABORT_EN
      for (int i = 0; i < 4; i++) plan.push_back(mk(1'b0, 1'b1, 4'hF, 4'h0));
      plan.push_back(mk(1'b1, 1'b0, 4'hF, 4'h0));
`endif
    end
    e = mk(1'b1, 1'b0, 4'hF, 4'h0);
    e.rv = 1'b1; e.rdy = 1'b1; e.rd = rd; e.rs = st;
    plan.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Issue a request and play the peripheral; cut>=0 stops after that many clocks
  task automatic run_txn(input logic [3:0] ct, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] data, input int cut);
    int n;
    build_plan(ct, sz, addr, data);
    @(negedge clk); #1;
    req_ct = ct; req_size = sz; req_addr = addr; req_data = data; req_valid = 1'b1;
    chk("req_ready_before_handshake", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = (cut < 0) ? plan.size() : cut;
    for (int k = 0; k < n; k++) begin
      ad_in = plan[k].din;
      expq.push_back(plan[k]);
      @(posedge clk); #1;
    end
    ad_in = 4'hF;
  endtask

  // Per-cycle comparison of DUT outputs against the queued expectation
  always begin : cmp
    ent_t e;
    logic bad;
    @(negedge clk);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      bad = (frame !== e.fr) || (ad_oe !== e.oe) || (e.oe && (ad_out !== e.ad)) ||
            (resp_valid !== e.rv) || (req_ready !== e.rdy) ||
            (e.rv && ((resp_data !== e.rd) || (resp_status !== e.rs)));
      if (bad) begin
        errors++;
        $display("FAIL bus[%0d] got fr=%b oe=%b ad=%h rv=%b rdy=%b rd=%h rs=%0d expected fr=%b oe=%b ad=%h rv=%b rdy=%b rd=%h rs=%0d",
                 ent_no, frame, ad_oe, ad_out, resp_valid, req_ready, resp_data, resp_status,
                 e.fr, e.oe, e.ad, e.rv, e.rdy, e.rd, e.rs);
      end
      ent_no++;
    end else if (rst_n && idle_chk) begin
      checks++;
      if ((frame !== 1'b1) || (ad_oe !== 1'b0) || (resp_valid !== 1'b0)) begin
        errors++;
        $display("FAIL idle got fr=%b oe=%b rv=%b expected fr=1 oe=0 rv=0", frame, ad_oe, resp_valid);
      end
    end
  end

  // Independent bus sniffer recovering address and write data from LAD
  int          sn_idx;
  int          sn_nd;
  logic [3:0]  sn_ct;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  initial begin sn_idx = 0; sn_nd = 8; sn_ct = 4'h0; out_addr = '0; out_data = '0; end
  always begin : sniff
    @(negedge clk);
    if (!rst_n) sn_idx = 0;
    else if (ad_oe && !frame && (ad_out == 4'h0)) begin
      sn_idx = 1; out_data = 32'd0;
    end else if (sn_idx > 0) begin
      if (sn_idx == 1) sn_ct = ad_out;
      else if (sn_idx == 2) sn_nd = (ad_out[1:0] == 2'd0) ? 2 : (ad_out[1:0] == 2'd1) ? 4 : 8;
      else if (sn_idx <= 10) out_addr = {out_addr[27:0], ad_out};
      else if (sn_ct[1] && (sn_idx <= 10 + sn_nd)) out_data[4 * (sn_idx - 11) +: 4] = ad_out;
      sn_idx = (sn_idx >= 10 + sn_nd) ? 0 : sn_idx + 1;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  logic [3:0] lit [19];
  int         lit_bad;

  initial begin
    checks = 0; errors = 0; ent_no = 0; idle_chk = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_ct = 4'h0; req_addr = '0; req_data = '0;
    req_size = 2'd0; ad_in = 4'hF;
    lit = '{4'h0, 4'h6, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'hF, 4'hE,
            4'h5, 4'hE, 4'hC, 4'h9, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
    #2;
    chk("rst_frame", {31'd0, frame}, 32'd1);
    chk("rst_oe", {31'd0, ad_oe}, 32'd0);
    chk("rst_ad", {28'd0, ad_out}, 32'hF);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_status", {30'd0, resp_status}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 chk("ready_before_first_edge", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_first_edge", {31'd0, req_ready}, 32'd1);
    idle_chk = 1'b1;

    // Pin the model with the hand-computed 4-byte write sequence
    per_q = '{4'h0};
    build_plan(4'h6, 2'd3, 32'h12347fe5, 32'h000069ce);
    lit_bad = 0;
    for (int i = 0; i < 19; i++) if (plan[i].ad !== lit[i]) lit_bad++;
    chk("model_write_nibbles", lit_bad, 0);
    chk("model_write_length", plan.size(), 25);
    chk("model_resp_at_24", {31'd0, plan[24].rv}, 32'd1);

    per_q = '{4'h0};
    run_txn(4'h6, 2'd3, 32'h12347fe5, 32'h000069ce, -1);
    chk("write_status", {30'd0, resp_status}, 32'd0);

    per_q = '{4'h5, 4'h5, 4'h0, 4'hE, 4'hC, 4'h9, 4'h6};
    run_txn(4'h4, 2'd1, 32'h12347fe5, 32'h0, -1);
    chk("read_data", resp_data, 32'h000069ce);
    chk("read_status", {30'd0, resp_status}, 32'd0);

    per_q.delete();
    for (int i = 0; i < 8; i++) per_q.push_back(4'hF);
    run_txn(4'h6, 2'd0, 32'h00000080, 32'h000000a5, -1);
    chk("timeout_status", {30'd0, resp_status}, 32'd2);

    per_q.delete();
    for (int i = 0; i < 7; i++) per_q.push_back(4'hF);
    per_q.push_back(4'h0);
    run_txn(4'h6, 2'd0, 32'h00000081, 32'h0000005a, -1);
    chk("seven_waits_status", {30'd0, resp_status}, 32'd0);

    per_q = '{4'h3, 4'h3, 4'h3, 4'h5, 4'h5, 4'h5, 4'h5, 4'h0};
    run_txn(4'h2, 2'd2, 32'hfedc0123, 32'hcafe1234, -1);
    chk("mixed_waits_status", {30'd0, resp_status}, 32'd0);

    per_q.delete();
    for (int i = 0; i < 7; i++) per_q.push_back(4'hF);
    per_q.push_back(4'h6);
    for (int i = 0; i < 7; i++) per_q.push_back(4'hF);
    per_q.push_back(4'h0);
    per_q.push_back(4'h1);
    per_q.push_back(4'h2);
    run_txn(4'h0, 2'd0, 32'h000003f8, 32'h0, -1);
    chk("restart_read_data", resp_data, 32'h00000021);

    per_q.delete();
    for (int i = 0; i < 20; i++) per_q.push_back(4'h6);
    per_q.push_back(4'h0);
    run_txn(4'h6, 2'd1, 32'h0000beef, 32'h00001357, -1);
    chk("long_wait_status", {30'd0, resp_status}, 32'd0);

    per_q = '{4'h5, 4'hA, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    run_txn(4'h4, 2'd3, 32'h00001000, 32'h0, -1);
    chk("sync_error_status", {30'd0, resp_status}, 32'd1);
    chk("sync_error_data", resp_data, 32'h87654321);

    // Reset in the middle of the address phase
    per_q = '{4'h0};
    run_txn(4'h6, 2'd3, 32'hdeadbeef, 32'h11223344, 6);
    #1 rst_n = 1'b0;
    #1;
    expq.delete();
    chk("midrst_frame", {31'd0, frame}, 32'd1);
    chk("midrst_oe", {31'd0, ad_oe}, 32'd0);
    chk("midrst_ad", {28'd0, ad_out}, 32'hF);
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_resp_data", resp_data, 32'd0);
    chk("midrst_resp_status", {30'd0, resp_status}, 32'd0);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 chk("midrst_ready_before_edge", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_ready_after_edge", {31'd0, req_ready}, 32'd1);

    per_q = '{4'h0};
    run_txn(4'h6, 2'd3, 32'ha5c31e0f, 32'h8badf00d, -1);
    chk("sniffer_addr", out_addr, 32'ha5c31e0f);
    chk("sniffer_data", out_data, 32'h8badf00d);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
